// File: rtl/keypad_scan_scheduler.sv
// keypad_scan_scheduler: 3x3 keypad column scanner, debouncer and event queue.
// Define KEYPAD_EVENT_FIFO_EN for a 4-deep event FIFO; otherwise one holding register.
module keypad_scan_scheduler #(
  parameter int CLK_DIV         = 50000,
  parameter int SETTLE_TICKS    = 2,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_enable,
  input  logic [2:0] row,
  output logic [2:0] column,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE, S_DRIVE, S_SAMPLE, S_NEXT
  } state_t;

  // 4'hF can never be a real code since both indices stop at 2
  localparam logic [3:0]  NONE     = 4'hF;
  localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);
  localparam logic [3:0]  SETTLE_N = 4'(SETTLE_TICKS);
  localparam logic [3:0]  DEB_N    = 4'(DEBOUNCE_FRAMES);

  logic [15:0] r_tick_cnt;
  logic        w_tick;
  state_t      r_state, w_state_nx;
  logic [1:0]  r_col_idx, w_col_nx;
  logic [3:0]  r_settle, w_settle_nx;
  logic [3:0]  r_frame_key, w_frame;
  logic [3:0]  r_cand, r_stable, w_cnt_nx;
  logic        r_latch;
  logic [2:0]  w_hits;
  logic [1:0]  w_row_idx;
  logic        w_sample, w_frame_end;
  logic        w_event, w_release, w_pop;
  logic        r_ovf;

  assign w_tick = scan_enable && (r_tick_cnt == TICK_MAX);

  // Scan tick divider, held at zero while scanning is off
  always_ff @(posedge clk) begin
    if (reset || !scan_enable) r_tick_cnt <= '0;
    else if (w_tick)           r_tick_cnt <= '0;
    else                       r_tick_cnt <= r_tick_cnt + 16'd1;
  end

  // Scan FSM next-state and column/settle bookkeeping
  always_comb begin
    w_state_nx  = r_state;
    w_col_nx    = r_col_idx;
    w_settle_nx = r_settle;
    unique case (r_state)
      S_IDLE: if (scan_enable) begin
        w_state_nx  = S_DRIVE;
        w_col_nx    = 2'd0;
        w_settle_nx = 4'd0;
      end
      S_DRIVE: begin
        if (!scan_enable) w_state_nx = S_IDLE;
        else if (w_tick) begin
          w_settle_nx = r_settle + 4'd1;
          if (w_settle_nx == SETTLE_N) w_state_nx = S_SAMPLE;
        end
      end
      S_SAMPLE: w_state_nx = scan_enable ? S_NEXT : S_IDLE;
      S_NEXT: begin
        if (!scan_enable) w_state_nx = S_IDLE;
        else begin
          w_state_nx  = S_DRIVE;
          w_col_nx    = (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;
          w_settle_nx = 4'd0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Scan FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_col_idx <= 2'd0;
      r_settle  <= 4'd0;
    end else begin
      r_state   <= w_state_nx;
      r_col_idx <= w_col_nx;
      r_settle  <= w_settle_nx;
    end
  end

  assign column = (r_state == S_IDLE) ? 3'b111
                : ~(3'b001 << r_col_idx);

  assign w_sample    = (r_state == S_SAMPLE) && scan_enable;
  assign w_frame_end = w_sample && (r_col_idx == 2'd2);
  assign w_hits      = ~row;

  // Lowest asserted row wins within a column
  always_comb begin
    w_row_idx = 2'd2;
    if (w_hits[1]) w_row_idx = 2'd1;
    if (w_hits[0]) w_row_idx = 2'd0;
  end

  // Column 0 starts a fresh frame; an earlier column's hit takes priority
  always_comb begin
    w_frame = NONE;
    if (r_col_idx != 2'd0 && r_frame_key != NONE) w_frame = r_frame_key;
    else if (|w_hits) w_frame = {w_row_idx, r_col_idx};
  end

  // Partial frame accumulator
  always_ff @(posedge clk) begin
    if (reset)         r_frame_key <= NONE;
    else if (w_sample) r_frame_key <= w_frame;
  end

  always_comb begin
    w_cnt_nx = 4'd1;
    if (w_frame == r_cand)
      w_cnt_nx = (r_stable == DEB_N) ? r_stable : r_stable + 4'd1;
  end

  assign w_event   = w_frame_end && (w_cnt_nx == DEB_N)
                  && (w_frame != NONE) && !r_latch;
  assign w_release = w_frame_end && (w_cnt_nx == DEB_N)
                  && (w_frame == NONE);

  // Debounce candidate, stable count and press latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand   <= NONE;
      r_stable <= 4'd0;
      r_latch  <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_cand   <= w_frame;
        r_stable <= w_cnt_nx;
      end
      if (w_event)        r_latch <= 1'b1;
      else if (w_release) r_latch <= 1'b0;
    end
  end

  assign overflow = r_ovf;

`ifdef KEYPAD_EVENT_FIFO_EN
  logic [3:0] r_fifo [4];
  logic [1:0] r_rd, r_wr;
  logic [2:0] r_cnt;
  logic       w_full, w_push;

  assign w_pop     = (r_cnt != 3'd0) && key_ack;
  assign w_full    = (r_cnt == 3'd4);
  assign w_push    = w_event && (!w_full || w_pop);
  assign key       = r_fifo[r_rd];
  assign key_valid = (r_cnt != 3'd0);

  // Event FIFO; a push and a pop in one clk are both taken
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= 4'h0;
      r_rd  <= 2'd0;
      r_wr  <= 2'd0;
      r_cnt <= 3'd0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= w_frame;
        r_wr         <= r_wr + 2'd1;
      end
      if (w_pop) r_rd <= r_rd + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
      r_ovf <= w_event && w_full && !w_pop;
    end
  end
`else
  logic [3:0] r_key;
  logic       r_valid;

  assign w_pop     = r_valid && key_ack;
  assign key       = r_key;
  assign key_valid = r_valid;

  // Single holding register; an acked slot may be refilled the same clk
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key   <= 4'h0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= w_event && r_valid && !w_pop;
      if (w_event && (!r_valid || w_pop)) begin
        r_key   <= w_frame;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan_scheduler.sv
// tb_keypad_scan_scheduler: directed checks of scan, debounce and event output.
// Honours KEYPAD_EVENT_FIFO_EN for the queued-event expectations.
module tb_keypad_scan_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_enable;
  logic [2:0] row;
  logic [2:0] column;
  logic [3:0] key;
  logic       key_valid;
  logic       key_ack;
  logic       overflow;
  logic [8:0] keys;

  int vec  = 0;
  int miss = 0;

  int         ev_cnt  = 0;
  logic [3:0] ev_key  = 4'h0;
  logic [2:0] ev_col  = 3'b000;
  int         ovf_cnt = 0;
  logic       prev_v  = 1'b0;

  keypad_scan_scheduler #(
    .CLK_DIV        (4),
    .SETTLE_TICKS   (2),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_enable(scan_enable),
    .row        (row),
    .column     (column),
    .key        (key),
    .key_valid  (key_valid),
    .key_ack    (key_ack),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low when its column is driven
  always_comb begin
    row = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !column[c]) row[r] = 1'b0;
  end

  // Event and overflow monitor
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (key_valid && !prev_v) begin
      ev_cnt++;
      ev_key = key;
      ev_col = column;
    end
    prev_v = key_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ack1;
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  task automatic press(input int idx, input int hold);
    keys = 9'b1 << idx;
    cyc(hold);
    keys = 9'b0;
    cyc(150);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    scan_enable = 1'b0;
    key_ack = 1'b0;
    keys = 9'b0;
    cyc(3);
    chk("rst_column", 32'(column), 32'(3'b111));
    chk("rst_key", 32'(key), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    reset = 1'b0;
    cyc(2);
    chk("idle_column", 32'(column), 32'(3'b111));
    scan_enable = 1'b1;
    cyc(1);
    chk("start_col0", 32'(column), 32'(3'b110));

    n = 0;
    while (column != 3'b101 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("col1_seen", 32'(column), 32'(3'b101));
    scan_enable = 1'b0;
    cyc(1);
    chk("drop_idle", 32'(column), 32'(3'b111));
    scan_enable = 1'b1;
    cyc(1);
    chk("restart_col0", 32'(column), 32'(3'b110));
    cyc(150);
    chk("quiet_no_event", 32'(ev_cnt), 32'd0);

    press(4, 20);
    chk("short_no_event", 32'(ev_cnt), 32'd0);
    chk("short_no_ovf", 32'(ovf_cnt), 32'd0);

    keys = 9'b1 << 5;
    cyc(150);
    chk("hold_one_event", 32'(ev_cnt), 32'd1);
    chk("hold_key", 32'(ev_key), 32'(4'b0110));
    chk("latency_col2", 32'(ev_col), 32'(3'b011));
    chk("hold_valid", 32'(key_valid), 32'h1);
    ack1;
    chk("ack_fall", 32'(key_valid), 32'h0);
    cyc(150);
    chk("no_repeat", 32'(ev_cnt), 32'd1);
    chk("no_repeat_valid", 32'(key_valid), 32'h0);
    keys = 9'b0;
    cyc(150);

    keys = (9'b1 << 0) | (9'b1 << 7);
    cyc(150);
    chk("multi_cnt", 32'(ev_cnt), 32'd2);
    chk("multi_key", 32'(ev_key), 32'(4'b0000));
    ack1;
    keys = 9'b0;
    cyc(150);
    chk("multi_only", 32'(ev_cnt), 32'd2);

    press(1, 150);
    press(8, 150);
    press(3, 150);
`ifdef KEYPAD_EVENT_FIFO_EN
    chk("fifo_ovf", 32'(ovf_cnt), 32'd0);
    chk("fifo_valid", 32'(key_valid), 32'h1);
    chk("fifo_k0", 32'(key), 32'(4'b0001));
    ack1;
    chk("fifo_valid1", 32'(key_valid), 32'h1);
    chk("fifo_k1", 32'(key), 32'(4'b1010));
    ack1;
    chk("fifo_k2", 32'(key), 32'(4'b0100));
    ack1;
    chk("fifo_empty", 32'(key_valid), 32'h0);
    chk("fifo_rises", 32'(ev_cnt), 32'd3);
`else
    chk("hold_ovf", 32'(ovf_cnt), 32'd2);
    chk("hold_first_key", 32'(key), 32'(4'b0001));
    chk("hold_first_valid", 32'(key_valid), 32'h1);
    chk("hold_rises", 32'(ev_cnt), 32'd3);
    ack1;
    chk("hold_drain", 32'(key_valid), 32'h0);
`endif

    keys = 9'b1 << 6;
    cyc(150);
    chk("pre_rst_valid", 32'(key_valid), 32'h1);
    chk("pre_rst_key", 32'(key), 32'(4'b1000));
    key_ack = 1'b1;
    reset = 1'b1;
    cyc(1);
    chk("rst2_column", 32'(column), 32'(3'b111));
    chk("rst2_key", 32'(key), 32'h0);
    chk("rst2_valid", 32'(key_valid), 32'h0);
    chk("rst2_ovf", 32'(overflow), 32'h0);
    key_ack = 1'b0;
    keys = 9'b0;
    reset = 1'b0;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
